// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch widths, reset vector, bubble encoding and the
// IF/ID pipeline register payload.
package cpu_defs_pkg;

   localparam int unsigned      ADDR_W    = 32;
   localparam logic [31:0]      RESET_PC  = 32'd0;
   localparam int unsigned      PC_STEP   = 4;
   localparam logic [31:0]      NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] instr;
      logic              valid;
   } if_id_t;

   typedef enum logic [1:0] {
      IFID_LOAD  = 2'd0,
      IFID_HOLD  = 2'd1,
      IFID_CLEAR = 2'd2
   } if_id_cmd_e;

   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.pc    = '0;
      b.instr = NOP_INSTR;
      b.valid = 1'b0;
      return b;
   endfunction

   // Branch targets are always word aligned; low bits are silently dropped.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. The command is decoded by the fetch stage; this
// block only loads, holds or clears to a bubble.
module if_id_reg
   import cpu_defs_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  if_id_cmd_e cmd,
   input  if_id_t     load_data,
   output if_id_t     q
);

   if_id_t ifid_q;
   if_id_t ifid_d;

   always_comb begin
      ifid_d = ifid_q;
      case (cmd)
         IFID_LOAD:  ifid_d = load_data;
         IFID_CLEAR: ifid_d = if_id_bubble();
         default:    ifid_d = ifid_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_q <= if_id_bubble();
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign q = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction memory and
// captures the returned word into the IF/ID register.
module if_fetch_stage #(
   parameter int unsigned ADDR_W   = cpu_defs_pkg::ADDR_W,
   parameter logic [31:0] RESET_PC = cpu_defs_pkg::RESET_PC,
   parameter int unsigned PC_STEP  = cpu_defs_pkg::PC_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [ADDR_W-1:0] imem_instru,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_instr,
   output logic              if_valid
);
   import cpu_defs_pkg::if_id_t;
   import cpu_defs_pkg::if_id_cmd_e;
   import cpu_defs_pkg::IFID_LOAD;
   import cpu_defs_pkg::IFID_HOLD;
   import cpu_defs_pkg::IFID_CLEAR;
   import cpu_defs_pkg::align_word;

   localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_seq;
   if_id_cmd_e        ifid_cmd;
   if_id_t            ifid_load;
   if_id_t            ifid_out;

   assign pc_seq = pc_q + PC_INC;

   // Priority below reset: branch > freeze > flush > sequential fetch.
   // A branch overrides a stall so the redirect is never lost.
   always_comb begin
      pc_d     = pc_seq;
      ifid_cmd = IFID_LOAD;
      if (branch_taken) begin
         pc_d     = align_word(branch_addr);
         ifid_cmd = IFID_CLEAR;
      end else if (freeze) begin
         pc_d     = pc_q;
         ifid_cmd = IFID_HOLD;
      end else if (flush) begin
         pc_d     = pc_seq;
         ifid_cmd = IFID_CLEAR;
      end
   end

   always_comb begin
      ifid_load.pc    = pc_seq;
      ifid_load.instr = imem_instru;
      ifid_load.valid = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .cmd       (ifid_cmd),
      .load_data (ifid_load),
      .q         (ifid_out)
   );

   assign imem_addr = pc_q;
   assign if_pc     = ifid_out.pc;
   assign if_instr  = ifid_out.instr;
   assign if_valid  = ifid_out.valid;

endmodule
